reg_op_sequencer: RTL

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_seq_pkg.sv | 43 ++++
 rtl/reg_op_seq_alu.sv | 43 ++++
 rtl/reg_op_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/reg_op_seq_pkg.sv
// reg_op_seq_pkg: shared widths, opcode/state enums and decode helpers for the register-op sequencer
package reg_op_seq_pkg;

   localparam int REG_W  = 16;
   localparam int RNUM_W = 3;
   localparam int OP_W   = 3;
   localparam int IMM_W  = 8;

   typedef enum logic [OP_W-1:0] {
      OP_MOVI = 3'd0,
      OP_MOV  = 3'd1,
      OP_ADD  = 3'd2,
      OP_AND  = 3'd3,
      OP_MVN  = 3'd4,
      OP_CMP  = 3'd5,
      OP_RSV6 = 3'd6,
      OP_RSV7 = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ_N = 3'd1,
      S_READ_M = 3'd2,
      S_EXEC   = 3'd3,
      S_WRITE  = 3'd4
   } state_e;

   function automatic logic [REG_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(REG_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

   // Opcodes MOVI..MVN produce a register result; CMP and reserved ops never write
   function automatic logic writes_rd(input op_e op);
      return op <= OP_MVN;
   endfunction

   // Two-operand ops fetch Rn first, single-operand ops only fetch Rm, the rest skip reads
   function automatic state_e first_state(input op_e op);
      return (op == OP_ADD || op == OP_AND || op == OP_CMP) ? S_READ_N :
             (op == OP_MOV || op == OP_MVN)                 ? S_READ_M : S_EXEC;
   endfunction

endpackage

// File: rtl/reg_op_seq_alu.sv
// reg_op_seq_alu: combinational datapath for the sequencer; flags port exists only with REG_OP_SEQ_FLAGS_EN
module reg_op_seq_alu
   import reg_op_seq_pkg::*;
(
   input  logic [REG_W-1:0] a,
   input  logic [REG_W-1:0] b,
   input  logic [IMM_W-1:0] imm,
   input  op_e              op,
`ifdef REG_OP_SEQ_FLAGS_EN
   output logic [2:0]       flags,
`endif
   output logic [REG_W-1:0] result
);

   logic [REG_W-1:0] sum;
   logic [REG_W-1:0] diff;

   // Select the operation result; CMP yields A-B so the flags see the difference
   always_comb begin
      sum  = a + b;
      diff = a - b;
      case (op)
         OP_MOVI: result = sext_imm(imm);
         OP_MOV:  result = b;
         OP_ADD:  result = sum;
         OP_AND:  result = a & b;
         OP_MVN:  result = ~b;
         OP_CMP:  result = diff;
         default: result = '0;
      endcase
   end

`ifdef REG_OP_SEQ_FLAGS_EN
   // {N,V,Z}: overflow only meaningful for add/subtract, logic ops report V=0
   always_comb begin
      flags = {result[REG_W-1],
               op == OP_ADD ? (a[REG_W-1] == b[REG_W-1]) && (sum[REG_W-1] != a[REG_W-1]) :
               op == OP_CMP ? (a[REG_W-1] != b[REG_W-1]) && (diff[REG_W-1] != a[REG_W-1]) : 1'b0,
               result == '0};
   end
`endif

endmodule

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: multi-cycle register-op FSM driving an external register file; optional flags via REG_OP_SEQ_FLAGS_EN
module reg_op_sequencer
   import reg_op_seq_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [OP_W-1:0]   req_op,
   input  logic [RNUM_W-1:0] req_rd,
   input  logic [RNUM_W-1:0] req_rn,
   input  logic [RNUM_W-1:0] req_rm,
   input  logic [IMM_W-1:0]  req_imm,
   output logic [RNUM_W-1:0] rf_readnum,
   output logic [RNUM_W-1:0] rf_writenum,
   output logic              rf_write,
   output logic [REG_W-1:0]  rf_data_in,
   input  logic [REG_W-1:0]  rf_data_out,
`ifdef REG_OP_SEQ_FLAGS_EN
   output logic [2:0]        flags,
`endif
   output logic              done
);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [RNUM_W-1:0] rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
   logic [IMM_W-1:0]  imm_q, imm_d;
   logic [REG_W-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
   logic [REG_W-1:0]  alu_result;
   logic              accept;
`ifdef REG_OP_SEQ_FLAGS_EN
   logic [2:0]        flags_q, flags_d, alu_flags;
`endif

   assign accept = req_valid && state_q == S_IDLE;

   reg_op_seq_alu u_alu (
      .a      (a_q),
      .b      (b_q),
      .imm    (imm_q),
      .op     (op_q),
`ifdef REG_OP_SEQ_FLAGS_EN
      .flags  (alu_flags),
`endif
      .result (alu_result)
   );

   // State and datapath registers; reset abandons any operation in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         op_q    <= OP_MOVI;
         rd_q    <= '0;
         rn_q    <= '0;
         rm_q    <= '0;
         imm_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
`ifdef REG_OP_SEQ_FLAGS_EN
         flags_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         rn_q    <= rn_d;
         rm_q    <= rm_d;
         imm_q   <= imm_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
`ifdef REG_OP_SEQ_FLAGS_EN
         flags_q <= flags_d;
`endif
      end
   end

   // Next-state sequencing: fetch operands as needed, then execute, then write back if the op has a result
   always_comb begin
      case (state_q)
         S_IDLE:   state_d = accept ? first_state(op_e'(req_op)) : S_IDLE;
         S_READ_N: state_d = S_READ_M;
         S_READ_M: state_d = S_EXEC;
         S_EXEC:   state_d = writes_rd(op_q) ? S_WRITE : S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Latch request fields on accept, capture operands during reads and the result in EXEC
   always_comb begin
      op_d    = accept ? op_e'(req_op) : op_q;
      rd_d    = accept ? req_rd : rd_q;
      rn_d    = accept ? req_rn : rn_q;
      rm_d    = accept ? req_rm : rm_q;
      imm_d   = accept ? req_imm : imm_q;
      a_d     = state_q == S_READ_N ? rf_data_out : a_q;
      b_d     = state_q == S_READ_M ? rf_data_out : b_q;
      c_d     = (state_q == S_EXEC && writes_rd(op_q)) ? alu_result : c_q;
`ifdef REG_OP_SEQ_FLAGS_EN
      flags_d = (state_q == S_EXEC && (op_q == OP_ADD || op_q == OP_AND ||
                                       op_q == OP_MVN || op_q == OP_CMP)) ? alu_flags : flags_q;
`endif
   end

   // Register-file and handshake outputs; write and done are masked by reset so an interrupted op leaves no trace
   always_comb begin
      req_ready   = state_q == S_IDLE;
      rf_readnum  = state_q == S_READ_N ? rn_q : state_q == S_READ_M ? rm_q : '0;
      rf_writenum = state_q == S_WRITE ? rd_q : '0;
      rf_write    = state_q == S_WRITE && !reset;
      rf_data_in  = c_q;
      done        = !reset && (state_q == S_WRITE || (state_q == S_EXEC && !writes_rd(op_q)));
`ifdef REG_OP_SEQ_FLAGS_EN
      flags       = flags_q;
`endif
   end

endmodule
